// File: rtl/alu_pwr_seq_if.sv
// Signal bundle between the always-on request side and the ALU power sequencer.
// The sequencer takes the slave view; the requester/ALU environment takes the master view.
interface alu_pwr_seq_if;
  logic       op_req;
  logic       op_ack;
  logic       alu_start;
  logic       alu_busy;
  logic       sleep_req;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       ready;
  logic [2:0] pwr_state;

  modport master (
    output op_req, alu_busy, sleep_req,
    input  op_ack, alu_start, alu_pwr_en, iso_en, ready, pwr_state
  );

  modport slave (
    input  op_req, alu_busy, sleep_req,
    output op_ack, alu_start, alu_pwr_en, iso_en, ready, pwr_state
  );
endinterface

// File: rtl/alu_pwr_seq.sv
// Power sequencer and operation gate for the switchable ALU domain: orders power and
// isolation changes, wakes on demand, and powers down on idle timeout or sleep request.
module alu_pwr_seq #(
  parameter int unsigned PWR_UP_CYC   = 4,
  parameter int unsigned ISO_CYC      = 2,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  alu_pwr_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWR_UP = 3'd1,
    S_ON     = 3'd2,
    S_DRAIN  = 3'd3,
    S_ISO    = 3'd4
  } state_t;

  localparam logic [7:0] PWR_LAST  = 8'(PWR_UP_CYC - 1);
  localparam logic [7:0] ISO_LAST  = 8'(ISO_CYC - 1);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic       IDLE_EN   = (IDLE_TIMEOUT != 0);

  state_t     state, state_nxt;
  logic [7:0] phase, phase_nxt;
  logic [7:0] idle, idle_nxt;
  logic       start_q;
  logic       ack;
  logic       active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_OFF;
      phase   <= '0;
      idle    <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      idle    <= idle_nxt;
      start_q <= ack;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    idle_nxt  = '0;
    ack       = 1'b0;
    active    = 1'b0;
    case (state)
      S_OFF: begin
        if (bus.op_req && !bus.sleep_req) begin
          state_nxt = S_PWR_UP;
          phase_nxt = '0;
        end
      end
      S_PWR_UP: begin
        phase_nxt = phase + 8'd1;
        if (phase == PWR_LAST) state_nxt = S_ON;
      end
      S_ON: begin
        // The start cycle and the busy window both block acceptance, giving 2-cycle spacing.
        ack      = bus.op_req && !bus.alu_busy && !start_q && !bus.sleep_req;
        active   = ack || bus.alu_busy || start_q;
        idle_nxt = active ? '0 : ((&idle) ? idle : idle + 8'd1);
        if (bus.sleep_req || (IDLE_EN && !active && idle == IDLE_LAST))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.alu_busy && !start_q) begin
          state_nxt = S_ISO;
          phase_nxt = '0;
        end
      end
      S_ISO: begin
        phase_nxt = phase + 8'd1;
        if (phase == ISO_LAST) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Power/isolation decode from the state register only, so power-off always implies isolation.
  assign bus.alu_pwr_en = (state != S_OFF);
  assign bus.iso_en     = (state == S_OFF) || (state == S_PWR_UP) || (state == S_ISO);
  assign bus.ready      = (state == S_ON);
  assign bus.pwr_state  = state;
  assign bus.op_ack     = ack;
  assign bus.alu_start  = start_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Bench for alu_pwr_seq: per-cycle comparison against a timer-based behavioural model,
// plus directed scenarios with hand-computed cycle expectations.
module tb_alu_pwr_seq;
  localparam int PUP  = 4;
  localparam int ISO  = 2;
  localparam int IDLE = 16;

  logic clk;
  logic rst;
  alu_pwr_seq_if bus();

  alu_pwr_seq #(
    .PWR_UP_CYC  (PUP),
    .ISO_CYC     (ISO),
    .IDLE_TIMEOUT(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model: mode code, remaining cycles of timed phase, idle cycles seen, pending start
  int ms = 0, mt = 0, midle = 0;
  bit mstart = 0, mvalid = 0;
  bit m_a, m_act;

  int busy_len = 3, busy_left = 0;
  bit start_prev = 0;
  int acks;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_ack();
    return (ms == 2) && (bus.op_req === 1'b1) && (bus.alu_busy === 1'b0) &&
           !mstart && (bus.sleep_req === 1'b0);
  endfunction

  // Behavioural model: modes as spec codes, timed phases as countdowns.
  initial forever begin
    @(posedge clk);
    m_a   = model_ack();
    m_act = m_a || (bus.alu_busy === 1'b1) || mstart;
    if (rst) begin
      ms = 0; mt = 0; midle = 0; mstart = 0; mvalid = 1;
    end else if (mvalid) begin
      case (ms)
        0: if (bus.op_req && !bus.sleep_req) begin ms = 1; mt = PUP; end
        1: begin
          mt--;
          if (mt == 0) begin ms = 2; midle = 0; end
        end
        2: begin
          if (bus.sleep_req || (IDLE != 0 && !m_act && midle + 1 >= IDLE)) ms = 3;
          midle = m_act ? 0 : midle + 1;
        end
        3: if (!bus.alu_busy && !mstart) begin ms = 4; mt = ISO; end
        4: begin
          mt--;
          if (mt == 0) ms = 0;
        end
        default: ms = 0;
      endcase
      mstart = m_a;
    end
  end

  // Per-cycle compare of all outputs against the model, plus the power/isolation invariant.
  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      logic [7:0] got, exp;
      got = {bus.pwr_state, bus.alu_pwr_en, bus.iso_en, bus.ready, bus.alu_start, bus.op_ack};
      exp = {3'(ms), ms != 0, (ms == 0 || ms == 1 || ms == 4), ms == 2, mstart, model_ack()};
      chk("outputs_vs_model", int'(got), int'(exp));
      chk("pwr_off_implies_iso", int'(bus.alu_pwr_en | bus.iso_en), 1);
    end
  end

  // ALU environment: busy for busy_len cycles starting the cycle after alu_start.
  initial forever begin
    @(negedge clk);
    start_prev = (bus.alu_start === 1'b1);
  end

  initial begin
    bus.alu_busy = 1'b0;
    forever begin
      step();
      if (start_prev) busy_left = busy_len;
      if (busy_left > 0) begin
        bus.alu_busy = 1'b1;
        busy_left--;
      end else begin
        bus.alu_busy = 1'b0;
      end
    end
  end

  task automatic wait_state(input int target, input int limit, input string name);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (int'(bus.pwr_state) == target) found = 1;
      else step();
    end
    chk(name, int'(found), 1);
  endtask

  task automatic wait_ack(input int limit, input string name);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (bus.op_ack === 1'b1) found = 1;
      else step();
    end
    chk(name, int'(found), 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.op_req = 1'b0;
    bus.sleep_req = 1'b0;
    step();
    step();

    // Reset state; cold request raised in cycle 0
    rst = 1'b0;
    bus.op_req = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(bus.pwr_state), 0);
    chk("rst_pwr_en", int'(bus.alu_pwr_en), 0);
    chk("rst_iso_en", int'(bus.iso_en), 1);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_start", int'(bus.alu_start), 0);
    chk("rst_ack", int'(bus.op_ack), 0);

    step(); @(negedge clk);                         // cycle 1
    chk("cold_c1_pwr_en", int'(bus.alu_pwr_en), 1);
    chk("cold_c1_state", int'(bus.pwr_state), 1);
    chk("cold_c1_iso", int'(bus.iso_en), 1);
    repeat (3) step(); @(negedge clk);              // cycle 4
    chk("cold_c4_iso", int'(bus.iso_en), 1);
    chk("cold_c4_ack", int'(bus.op_ack), 0);
    step(); @(negedge clk);                         // cycle 5
    chk("cold_c5_iso", int'(bus.iso_en), 0);
    chk("cold_c5_ready", int'(bus.ready), 1);
    chk("cold_c5_ack", int'(bus.op_ack), 1);
    step(); bus.op_req = 1'b0; @(negedge clk);      // cycle 6
    chk("cold_c6_start", int'(bus.alu_start), 1);
    step(); @(negedge clk);                         // cycle 7
    chk("cold_c7_start", int'(bus.alu_start), 0);

    // Idle timeout: busy 7..9, so N = 10
    repeat (3) step(); @(negedge clk);
    chk("idle_n_on", int'(bus.pwr_state), 2);
    repeat (15) step(); @(negedge clk);             // N+15
    chk("idle_n15_on", int'(bus.pwr_state), 2);
    step(); @(negedge clk);                         // N+16
    chk("idle_n16_drain", int'(bus.pwr_state), 3);
    step(); @(negedge clk);                         // N+17
    chk("idle_n17_iso", int'(bus.pwr_state), 4);
    chk("idle_n17_pwr", int'(bus.alu_pwr_en), 1);
    chk("idle_n17_isoen", int'(bus.iso_en), 1);
    step(); @(negedge clk);                         // N+18
    chk("idle_n18_iso", int'(bus.pwr_state), 4);
    step(); @(negedge clk);                         // N+19
    chk("idle_n19_off", int'(bus.pwr_state), 0);
    chk("idle_n19_pwr", int'(bus.alu_pwr_en), 0);

    // Back-to-back with op_req held: acks at 5, 10, 15, 20, 25
    step();
    bus.op_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.op_ack === 1'b1) begin
        chk("b2b_ack_cycle", k, 5 * (acks + 1));
        chk("b2b_ack_blocked", int'(bus.alu_start | bus.alu_busy), 0);
        acks++;
      end
      step();
    end
    bus.op_req = 1'b0;
    chk("b2b_ack_count", acks, 5);
    wait_state(0, 40, "b2b_timeout_off");

    // Sleep while busy (busy 6 cycles), then held request under sleep
    busy_len = 6;
    step();
    bus.op_req = 1'b1;
    wait_ack(20, "sleep_wake_ack");
    step(); bus.op_req = 1'b0; @(negedge clk);      // s
    chk("sleep_s_start", int'(bus.alu_start), 1);
    step(); bus.sleep_req = 1'b1; bus.op_req = 1'b1; @(negedge clk);  // s+1
    chk("sleep_s1_on", int'(bus.pwr_state), 2);
    chk("sleep_s1_noack", int'(bus.op_ack), 0);
    step(); @(negedge clk);                         // s+2
    chk("sleep_s2_drain", int'(bus.pwr_state), 3);
    repeat (4) step(); @(negedge clk);              // s+6
    chk("sleep_s6_drain", int'(bus.pwr_state), 3);
    step(); @(negedge clk);                         // s+7
    chk("sleep_s7_drain", int'(bus.pwr_state), 3);
    step(); @(negedge clk);                         // s+8
    chk("sleep_s8_iso", int'(bus.pwr_state), 4);
    chk("sleep_s8_pwr", int'(bus.alu_pwr_en), 1);
    step(); @(negedge clk);                         // s+9
    chk("sleep_s9_iso", int'(bus.pwr_state), 4);
    step(); @(negedge clk);                         // s+10
    chk("sleep_s10_off", int'(bus.pwr_state), 0);
    repeat (3) step(); @(negedge clk);              // s+13
    chk("sleep_hold_off", int'(bus.pwr_state), 0);
    step(); bus.sleep_req = 1'b0; @(negedge clk);   // s+14
    chk("sleep_drop_off", int'(bus.pwr_state), 0);
    step(); @(negedge clk);                         // s+15
    chk("sleep_drop_wake", int'(bus.pwr_state), 1);
    step();
    wait_ack(10, "wake2_ack");

    // Reset in first ISO cycle
    busy_len = 1;
    step(); bus.op_req = 1'b0; bus.sleep_req = 1'b1;
    step();
    wait_state(4, 10, "reach_iso");
    rst = 1'b1;
    step(); rst = 1'b0; bus.sleep_req = 1'b0; bus.op_req = 1'b1; @(negedge clk);
    chk("rst_iso_state", int'(bus.pwr_state), 0);
    chk("rst_iso_pwr", int'(bus.alu_pwr_en), 0);
    chk("rst_iso_isoen", int'(bus.iso_en), 1);

    // Reset in PWR_UP cycle 2
    step(); step(); @(negedge clk);
    chk("pwrup_c2_state", int'(bus.pwr_state), 1);
    rst = 1'b1;
    step(); rst = 1'b0; @(negedge clk);
    chk("rst_pwrup_state", int'(bus.pwr_state), 0);
    chk("rst_pwrup_pwr", int'(bus.alu_pwr_en), 0);
    chk("rst_pwrup_iso", int'(bus.iso_en), 1);
    chk("rst_pwrup_ready", int'(bus.ready), 0);
    step(); @(negedge clk);
    chk("rst_rewake", int'(bus.pwr_state), 1);
    step();
    wait_ack(10, "final_ack");
    step(); bus.op_req = 1'b0;
    step();
    wait_state(0, 40, "final_off");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
